// File: rtl/smem_core.sv
// smem_core: single-port 1024x16 synchronous RAM with optional address and output registers.
// Latency: 1 clock from addr to dout, plus 1 for each of addr_en and dout_en (3 max); parity_out follows dout.
// Backpressure: none; blk_select=0 suppresses reads/writes; parity enabled by SMEM_PARITY_EN (else tied 0).
module smem_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  blk_select,
  input  logic                  addr_en,
  input  logic                  dout_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  parity_out
);

  // Storage; never reset so preloaded contents survive rst.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [DATA_WIDTH-1:0] r_rd_q;
  logic [DATA_WIDTH-1:0] r_dout_q;
  logic [ADDR_WIDTH-1:0] w_a_eff;
  logic                  w_access;

  // Effective address may switch between live and registered every cycle.
  assign w_a_eff  = addr_en ? r_addr_q : addr;
  assign w_access = blk_select & ~rst;

  // Address register captures addr every clock regardless of enables.
  always_ff @(posedge clk) begin
    if (rst) r_addr_q <= '0;
    else     r_addr_q <= addr;
  end

  // Write port; suppressed in reset and when the block is deselected.
  always_ff @(posedge clk) begin
    if (w_access && wr_en) mem[w_a_eff] <= din;
  end

  // Read register samples old contents, giving read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (rst)                   r_rd_q <= '0;
    else if (w_access && rd_en) r_rd_q <= mem[w_a_eff];
  end

  // Output pipeline register always follows the read register.
  always_ff @(posedge clk) begin
    if (rst) r_dout_q <= '0;
    else     r_dout_q <= r_rd_q;
  end

  assign dout = dout_en ? r_dout_q : r_rd_q;

`ifdef SMEM_PARITY_EN
  // Even parity over whatever dout currently shows.
  assign parity_out = ^dout;
`else
  assign parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_smem_core.sv
// tb_smem_core: randomized and directed checks of smem_core against a word-level model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_smem_core;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DP = 1024;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en, blk_select, addr_en, dout_en;
  logic [DW-1:0] din;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          parity_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory contents plus the values visible at each stage.
  logic [DW-1:0] m_mem [0:DP-1];
  logic [AW-1:0] m_prev_addr;
  logic [DW-1:0] m_read_word;
  logic [DW-1:0] m_late_word;

  always #5 clk = ~clk;

  smem_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .blk_select(blk_select), .addr_en(addr_en), .dout_en(dout_en),
    .dout(dout), .parity_out(parity_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_parity(input logic [DW-1:0] v);
`ifdef SMEM_PARITY_EN
    return ($countones(v) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic preload(input int a, input logic [DW-1:0] v);
    dut.mem[a] = v;
    m_mem[a]   = v;
  endtask

  // One clock of stimulus; model advances on the same edge, outputs checked 1 time unit later.
  task automatic cyc(input logic r, input logic w, input logic rd, input logic b,
                     input logic ae, input logic de, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    logic [AW-1:0] ea;
    logic [DW-1:0] exp;
    rst = r; wr_en = w; rd_en = rd; blk_select = b;
    addr_en = ae; dout_en = de; addr = a; din = d;
    @(posedge clk);
    ea = ae ? m_prev_addr : a;
    if (r) begin
      m_prev_addr = '0;
      m_read_word = '0;
      m_late_word = '0;
    end else begin
      m_late_word = m_read_word;
      if (b && rd) m_read_word = m_mem[ea];
      if (b && w)  m_mem[ea] = d;
      m_prev_addr = a;
    end
    #1;
    exp = de ? m_late_word : m_read_word;
    check("dout", {16'h0, dout}, {16'h0, exp});
    check("parity", {31'h0, parity_out}, {31'h0, exp_parity(exp)});
  endtask

  // Measures clocks from applying addr 5 until 16'h1234 appears on dout.
  task automatic latency(input logic ae, input logic de, input int exp_lat);
    int found;
    found = 0;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, ae, de, 10'd6, 16'h0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, ae, de, 10'd5, 16'h0);
      if (found == 0 && dout === 16'h1234) found = k;
    end
    check($sformatf("latency_%0b%0b", ae, de), found, exp_lat);
  endtask

  initial begin
    logic [DW-1:0] wv [0:9];
    logic [31:0]   rv;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; blk_select = 1'b0;
    addr_en = 1'b0; dout_en = 1'b0; addr = '0; din = '0;
    m_prev_addr = '0; m_read_word = '0; m_late_word = '0;
    for (int i = 0; i < DP; i++) begin
      rv = $urandom;
      preload(i, rv[DW-1:0]);
    end
    preload(0, 16'hFFFF);

    // Reset with a read pending: outputs zero, memory untouched.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 16'h0);
    check("rst_dout", {16'h0, dout}, 32'h0);
    check("rst_parity", {31'h0, parity_out}, 32'h0);
    check("rst_mem0", {16'h0, dut.mem[0]}, 32'h0000_FFFF);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0, 16'h0);
    check("rst_dout_q", {16'h0, dout}, 32'h0);

    // Write 0..9 then read back through the output register.
    for (int i = 0; i < 10; i++) begin
      rv = $urandom;
      wv[i] = rv[DW-1:0];
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, AW'(i), wv[i]);
    end
    for (int i = 0; i <= 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, (i < 10) ? AW'(i) : 10'd0, 16'h0);
      if (i >= 1) check($sformatf("wr_rd_%0d", i - 1), {16'h0, dout}, {16'h0, wv[i - 1]});
    end

    // Latency matrix.
    preload(6, 16'h5555);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd5, 16'h1234);
    latency(1'b0, 1'b0, 1);
    latency(1'b0, 1'b1, 2);
    latency(1'b1, 1'b0, 2);
    latency(1'b1, 1'b1, 3);

    // Deselected block: no write, read register holds.
    preload(2, 16'h2222);
    preload(3, 16'h3333);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 16'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd3, 16'hAAAA);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd3, 16'hAAAA);
    check("blk_dout", {16'h0, dout}, 32'h0000_2222);
    check("blk_mem3", {16'h0, dut.mem[3]}, 32'h0000_3333);

    // Read-before-write collision.
    preload(7, 16'h0F0F);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd7, 16'h00FF);
    check("rbw_old", {16'h0, dout}, 32'h0000_0F0F);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd7, 16'h0);
    check("rbw_new", {16'h0, dout}, 32'h0000_00FF);

    // Parity on odd and even weight words.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd20, 16'h0001);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd21, 16'h0003);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd20, 16'h0);
`ifdef SMEM_PARITY_EN
    check("par_odd", {31'h0, parity_out}, 32'h1);
`else
    check("par_odd", {31'h0, parity_out}, 32'h0);
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd21, 16'h0);
    check("par_even", {31'h0, parity_out}, 32'h0);

    // Random traffic on a small address window to force reuse and collisions.
    for (int n = 0; n < 400; n++) begin
      rv = $urandom;
      cyc(rv[5:0] == 6'd0, rv[6], rv[7], rv[9:8] != 2'b00, rv[10], rv[11],
          {6'h0, rv[15:12]}, rv[31:16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
